// File: rtl/ovf_exception_unit.sv
// X-stage overflow exception unit: classifies ALU and mul/div overflow, registers the X/M
// exception flag and cause code, queues unmasked codes in a FIFO, and counts events per cause.
module ovf_exception_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            global_opcode,
  input  logic [4:0]            alu_opcode,
  input  logic                  alu_ovf,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  muldiv_start,
  input  logic                  muldiv_done,
  input  logic                  muldiv_ovf,
  input  logic [4:0]            mask,
  input  logic                  fifo_pop,
  output logic                  fifo_valid,
  output logic [2:0]            fifo_code,
  output logic                  fifo_overrun,
  input  logic [2:0]            cnt_sel,
  input  logic                  cnt_clear,
  output logic [CNT_WIDTH-1:0]  cnt_value,
  output logic                  ovf,
  output logic [DATA_WIDTH-1:0] xm_o_ovf,
  output logic                  dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              kind_q, kind_d;
  logic                    ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]   xm_q, xm_d;
  logic [2:0]              alu_code, md_code;
  logic                    evt;
  logic [2:0]              evt_code;
  logic [4:0]              code_onehot;
  logic                    push;

  logic [2:0]              mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]             count_q, count_d;
  logic                    overrun_q, overrun_d;
  logic                    full, pop_ok, push_ok;

  logic [CNT_WIDTH-1:0]    cnt_q [1:5];

  // Instruction decode into cause codes; 0 means "not this class of instruction".
  always_comb begin
    alu_code = 3'd0;
    md_code  = 3'd0;
    if (global_opcode == 5'b00101) begin
      alu_code = 3'd2;
    end else if (global_opcode == 5'b00000) begin
      case (alu_opcode)
        5'b00000: alu_code = 3'd1;
        5'b00001: alu_code = 3'd3;
        5'b00110: md_code  = 3'd4;
        5'b00111: md_code  = 3'd5;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    evt      = 1'b0;
    evt_code = 3'd0;
    case (state_q)
      ST_IDLE: begin
        if (alu_code != 3'd0 && alu_ovf && !stall && !flush) begin
          evt      = 1'b1;
          evt_code = alu_code;
        end
        if (muldiv_start && md_code != 3'd0 && !flush) begin
          state_d = ST_BUSY;
          kind_d  = md_code;
        end
      end
      ST_BUSY: begin
        // A flush aborts the op even if the result arrives in the same cycle.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (muldiv_done) begin
          state_d = ST_IDLE;
          if (muldiv_ovf) begin
            evt      = 1'b1;
            evt_code = kind_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    code_onehot = 5'd1 << (evt_code - 3'd1);
    push        = evt && ((mask & code_onehot) == 5'd0);
    ovf_d       = push;
    xm_d        = push ? {{(DATA_WIDTH-3){1'b0}}, evt_code} : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kind_q  <= 3'd0;
      ovf_q   <= 1'b0;
      xm_q    <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      ovf_q   <= ovf_d;
      xm_q    <= xm_d;
    end
  end

  assign ovf       = ovf_q;
  assign xm_o_ovf  = xm_q;
  assign dbg_state = state_q;

  // FIFO: when full, a simultaneous pop frees the slot the push needs.
  always_comb begin
    full      = (count_q == (AW+1)'(FIFO_DEPTH));
    pop_ok    = fifo_pop && (count_q != '0);
    push_ok   = push && (!full || pop_ok);
    wr_d      = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d      = pop_ok ? rd_q + 1'b1 : rd_q;
    count_d   = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    overrun_d = overrun_q;
    if (cnt_clear) begin
      overrun_d = 1'b0;
    end else if (push && full && !pop_ok) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_q] <= evt_code;
    end
  end

  assign fifo_valid   = (count_q != '0);
  assign fifo_code    = fifo_valid ? mem_q[rd_q] : 3'd0;
  assign fifo_overrun = overrun_q;

  // Counters see every raw event, masked or not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= 5; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= 5; k++) begin
        if (cnt_clear) begin
          cnt_q[k] <= '0;
        end else if (evt && evt_code == k[2:0] && cnt_q[k] != '1) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_value = '0;
    case (cnt_sel)
      3'd1: cnt_value = cnt_q[1];
      3'd2: cnt_value = cnt_q[2];
      3'd3: cnt_value = cnt_q[3];
      3'd4: cnt_value = cnt_q[4];
      3'd5: cnt_value = cnt_q[5];
      default: cnt_value = '0;
    endcase
  end

endmodule

// File: tb/tb_ovf_exception_unit.sv
// Directed bench for ovf_exception_unit, built with 2-bit counters so saturation is reachable.
module tb_ovf_exception_unit;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    global_opcode, alu_opcode, mask;
  logic          alu_ovf, stall, flush, muldiv_start, muldiv_done, muldiv_ovf;
  logic          fifo_pop, fifo_valid, fifo_overrun, cnt_clear, ovf, dbg_state;
  logic [2:0]    fifo_code, cnt_sel;
  logic [CW-1:0] cnt_value;
  logic [DW-1:0] xm_o_ovf;

  logic [2:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  ovf_exception_unit #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .global_opcode(global_opcode), .alu_opcode(alu_opcode),
    .alu_ovf(alu_ovf), .stall(stall), .flush(flush), .muldiv_start(muldiv_start),
    .muldiv_done(muldiv_done), .muldiv_ovf(muldiv_ovf), .mask(mask), .fifo_pop(fifo_pop),
    .fifo_valid(fifo_valid), .fifo_code(fifo_code), .fifo_overrun(fifo_overrun),
    .cnt_sel(cnt_sel), .cnt_clear(cnt_clear), .cnt_value(cnt_value), .ovf(ovf),
    .xm_o_ovf(xm_o_ovf), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    global_opcode = 5'd0; alu_opcode = 5'd0; alu_ovf = 1'b0; stall = 1'b0;
    flush = 1'b0; muldiv_start = 1'b0; muldiv_done = 1'b0; muldiv_ovf = 1'b0;
    fifo_pop = 1'b0; cnt_clear = 1'b0;
  endtask

  task automatic alu_event(input logic [2:0] code);
    global_opcode = (code == 3'd2) ? 5'b00101 : 5'b00000;
    alu_opcode    = (code == 3'd3) ? 5'b00001 : 5'b00000;
    alu_ovf       = 1'b1;
  endtask

  task automatic check_head(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_valid"}, {31'd0, fifo_valid}, 32'd0);
    end else begin
      check({tag, "_valid"}, {31'd0, fifo_valid}, 32'd1);
      check({tag, "_code"}, {29'd0, fifo_code}, {29'd0, exp_q[0]});
    end
  endtask

  task automatic pop();
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  initial begin
    quiet();
    mask = 5'd0; cnt_sel = 3'd0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_xm", xm_o_ovf, 32'd0);
    check("rst_valid", {31'd0, fifo_valid}, 32'd0);
    check("rst_code", {29'd0, fifo_code}, 32'd0);
    check("rst_overrun", {31'd0, fifo_overrun}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);

    // 1: add overflow, then one cycle later the flag drops; stalled add is ignored
    alu_event(3'd1); tick(); quiet(); exp_q.push_back(3'd1);
    check("add_ovf", {31'd0, ovf}, 32'd1);
    check("add_xm", xm_o_ovf, 32'd1);
    check_head("add_fifo");
    tick();
    check("add_ovf_drop", {31'd0, ovf}, 32'd0);
    check("add_xm_drop", xm_o_ovf, 32'd0);
    pop();
    check_head("add_popped");
    alu_event(3'd1); stall = 1'b1; tick(); quiet();
    check("stall_ovf", {31'd0, ovf}, 32'd0);
    check_head("stall_fifo");
    cnt_sel = 3'd1; #1;
    check("cnt_add", {30'd0, cnt_value}, 32'd1);

    // 2: mul with three idle cycles, then overflow on done
    alu_opcode = 5'b00110; muldiv_start = 1'b1; tick(); quiet();
    check("mul_busy", {31'd0, dbg_state}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check("mul_wait_ovf", {31'd0, ovf}, 32'd0);
    muldiv_done = 1'b1; muldiv_ovf = 1'b1; tick(); quiet(); exp_q.push_back(3'd4);
    check("mul_ovf", {31'd0, ovf}, 32'd1);
    check("mul_xm", xm_o_ovf, 32'd4);
    check("mul_idle", {31'd0, dbg_state}, 32'd0);
    check_head("mul_fifo");
    cnt_sel = 3'd4; #1;
    check("cnt_mul", {30'd0, cnt_value}, 32'd1);
    pop();
    // div flushed: a later done is ignored
    alu_opcode = 5'b00111; muldiv_start = 1'b1; tick(); quiet();
    check("div_busy", {31'd0, dbg_state}, 32'd1);
    flush = 1'b1; tick(); quiet();
    check("div_flushed", {31'd0, dbg_state}, 32'd0);
    muldiv_done = 1'b1; muldiv_ovf = 1'b1; tick(); quiet();
    check("div_late_ovf", {31'd0, ovf}, 32'd0);
    check_head("div_late_fifo");
    cnt_sel = 3'd5; #1;
    check("cnt_div", {30'd0, cnt_value}, 32'd0);

    // 3: masked sub overflow still counts
    mask = 5'b00100;
    alu_event(3'd3); tick(); quiet();
    check("mask_ovf", {31'd0, ovf}, 32'd0);
    check("mask_xm", xm_o_ovf, 32'd0);
    check_head("mask_fifo");
    cnt_sel = 3'd3; #1;
    check("cnt_sub_masked", {30'd0, cnt_value}, 32'd1);
    mask = 5'd0;

    // 4: five pushes into a 4-deep FIFO, then push+pop while full
    begin
      logic [2:0] seq [5] = '{3'd2, 3'd1, 3'd3, 3'd2, 3'd1};
      for (int i = 0; i < 5; i++) begin
        alu_event(seq[i]); tick(); quiet();
        if (exp_q.size() < 4) exp_q.push_back(seq[i]);
      end
    end
    check("overrun_set", {31'd0, fifo_overrun}, 32'd1);
    check_head("full_head");
    alu_event(3'd3); fifo_pop = 1'b1; tick(); quiet();
    void'(exp_q.pop_front()); exp_q.push_back(3'd3);
    check("pushpop_overrun", {31'd0, fifo_overrun}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("drain%0d", i));
      pop();
    end
    check_head("drained");
    cnt_sel = 3'd1; #1;
    check("cnt_add_sat", {30'd0, cnt_value}, 32'd3);

    // 5: addi saturation with cause masked, then clear beats a same-cycle increment
    mask = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      alu_event(3'd2); tick(); quiet();
    end
    cnt_sel = 3'd2; #1;
    check("cnt_addi_sat", {30'd0, cnt_value}, 32'd3);
    check_head("addi_masked_fifo");
    alu_event(3'd2); cnt_clear = 1'b1; tick(); quiet();
    check("cnt_clear_wins", {30'd0, cnt_value}, 32'd0);
    check("overrun_cleared", {31'd0, fifo_overrun}, 32'd0);
    cnt_sel = 3'd6; #1;
    check("cnt_sel6", {30'd0, cnt_value}, 32'd0);
    mask = 5'd0;

    // 6: asynchronous reset while BUSY drops everything
    alu_event(3'd1); tick(); quiet(); exp_q.push_back(3'd1);
    alu_opcode = 5'b00110; muldiv_start = 1'b1; tick(); quiet();
    check("pre_rst_busy", {31'd0, dbg_state}, 32'd1);
    check_head("pre_rst_fifo");
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    cnt_sel = 3'd1;
    #1;
    check("arst_state", {31'd0, dbg_state}, 32'd0);
    check("arst_valid", {31'd0, fifo_valid}, 32'd0);
    check("arst_cnt", {30'd0, cnt_value}, 32'd0);
    #1 reset = 1'b0;
    alu_opcode = 5'b00110; muldiv_done = 1'b1; muldiv_ovf = 1'b1; tick(); quiet();
    check("post_rst_ovf", {31'd0, ovf}, 32'd0);
    check("post_rst_xm", xm_o_ovf, 32'd0);
    check_head("post_rst_fifo");
    cnt_sel = 3'd4; #1;
    check("post_rst_cnt", {30'd0, cnt_value}, 32'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
